// File: rtl/sbox_rnd_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sbox_rnd_gen_if
// Brief    : Seed handshake, control and mask-field bundle of sbox_rnd_gen.
// Revision : 1.0
// ============================================================================
interface sbox_rnd_gen_if #(
  parameter int SHARES     = 2,
  parameter int BLIND_BITS = 8
);
  localparam int ZM_W = 2 * SHARES * (SHARES - 1);
  localparam int ZI_W = SHARES * (SHARES - 1);

  logic [31:0]           SeedxDI;
  logic                  SeedValidxSI;
  logic                  SeedReadyxSO;
  logic                  ReseedxSI;
  logic                  EnxSI;
  logic                  RndValidxSO;
  logic [ZM_W-1:0]       Zmul1xDO;
  logic [ZM_W-1:0]       Zmul2xDO;
  logic [ZM_W-1:0]       Zmul3xDO;
  logic [ZI_W-1:0]       Zinv1xDO;
  logic [ZI_W-1:0]       Zinv2xDO;
  logic [ZI_W-1:0]       Zinv3xDO;
  logic [BLIND_BITS-1:0] BxDO;
  logic                  ErrxSO;

  modport slave (
    input  SeedxDI, SeedValidxSI, ReseedxSI, EnxSI,
    output SeedReadyxSO, RndValidxSO, Zmul1xDO, Zmul2xDO, Zmul3xDO,
           Zinv1xDO, Zinv2xDO, Zinv3xDO, BxDO, ErrxSO
  );

  modport master (
    output SeedxDI, SeedValidxSI, ReseedxSI, EnxSI,
    input  SeedReadyxSO, RndValidxSO, Zmul1xDO, Zmul2xDO, Zmul3xDO,
           Zinv1xDO, Zinv2xDO, Zinv3xDO, BxDO, ErrxSO
  );
endinterface
`default_nettype wire

// File: rtl/sbox_rnd_gen.sv
`default_nettype none
// ============================================================================
// Module   : sbox_rnd_gen
// Brief    : Fresh-mask source for the masked AES S-box: bank of 32-bit Galois
//            LFSR lanes leaping 32 steps per cycle. Optional health monitor is
//            enabled by defining RND_HEALTH_EN.
// Revision : 1.0
// ============================================================================
module sbox_rnd_gen #(
  parameter int SHARES     = 2,
  parameter int BLIND_BITS = 8,
  parameter int WARMUP     = 16
) (
  input  logic          ClkxCI,
  input  logic          RstxRI,
  sbox_rnd_gen_if.slave bus
);
  localparam int ZM_W   = 2 * SHARES * (SHARES - 1);
  localparam int ZI_W   = SHARES * (SHARES - 1);
  localparam int RND_W  = 3 * ZM_W + 3 * ZI_W + BLIND_BITS;
  localparam int LANES  = (RND_W + 31) / 32;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int OFF_ZM2 = ZM_W;
  localparam int OFF_ZM3 = 2 * ZM_W;
  localparam int OFF_ZI1 = 3 * ZM_W;
  localparam int OFF_ZI2 = 3 * ZM_W + ZI_W;
  localparam int OFF_ZI3 = 3 * ZM_W + 2 * ZI_W;
  localparam int OFF_B   = 3 * ZM_W + 3 * ZI_W;
  localparam logic [31:0] POLY_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WARMUP   = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic [LANES-1:0][31:0] lane_q, lane_d;
  logic                   err_q, err_d;
  logic                   load_en;
  logic                   leap_en;
  logic                   seed_done;
  logic                   health_fail;
  logic [31:0]            seed_fix;
  logic [RND_W-1:0]       rnd;

  // Right-shifting Galois LFSR, 32 steps unrolled.
  function automatic logic [31:0] leap32(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      v = (v >> 1) ^ (v[0] ? POLY_MASK : 32'h0);
    end
    return v;
  endfunction

  // A zero seed would lock the lane, so it is replaced by 1.
  assign seed_fix  = (bus.SeedxDI == 32'h0) ? 32'h1 : bus.SeedxDI;
  assign load_en   = (state_q == ST_LOAD) && bus.SeedValidxSI && !bus.ReseedxSI;
  assign leap_en   = !bus.ReseedxSI &&
                     ((state_q == ST_WARMUP) || ((state_q == ST_RUN) && bus.EnxSI));
  assign seed_done = load_en && (cnt_q == CNT_W'(LANES - 1));

  always_comb begin
    lane_d = lane_q;
    for (int l = 0; l < LANES; l++) begin
      if (load_en && (cnt_q == CNT_W'(l))) begin
        lane_d[l] = seed_fix;
      end else if (leap_en) begin
        lane_d[l] = leap32(lane_q[l]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    err_d   = err_q;
    case (state_q)
      ST_UNSEEDED: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
      ST_LOAD: begin
        if (seed_done) begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
          warm_d  = '0;
          err_d   = 1'b0;
        end else if (load_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WARMUP: begin
        warm_d = warm_q + WARM_W'(1);
        if (warm_q == WARM_W'(WARMUP - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
      end
    endcase
    if (bus.ReseedxSI) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end
    if (health_fail) begin
      state_d = ST_UNSEEDED;
      err_d   = 1'b1;
    end
  end

`ifdef RND_HEALTH_EN
  logic [LANES-1:0][1:0] rep_q, rep_d;
  logic [LANES-1:0]      lane_bad;

  // Repetition count per lane across leaps; a reload restarts it.
  always_comb begin
    rep_d    = rep_q;
    lane_bad = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_bad[l] = (rep_q[l] >= 2'd2) || (lane_q[l] == 32'h0);
      if (load_en && (cnt_q == CNT_W'(l))) begin
        rep_d[l] = 2'd0;
      end else if (leap_en) begin
        if (lane_d[l] == lane_q[l]) begin
          rep_d[l] = (rep_q[l] == 2'd3) ? 2'd3 : rep_q[l] + 2'd1;
        end else begin
          rep_d[l] = 2'd0;
        end
      end
    end
  end

  assign health_fail = ((state_q == ST_WARMUP) || (state_q == ST_RUN)) && (|lane_bad);

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      state_q <= ST_UNSEEDED;
      cnt_q   <= '0;
      warm_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
    end
  end

  // Lane 0 occupies the LSBs; fields are packed LSB first.
  assign rnd = RND_W'(lane_q);

  assign bus.SeedReadyxSO = (state_q == ST_LOAD);
  assign bus.RndValidxSO  = (state_q == ST_RUN);
  assign bus.ErrxSO       = err_q;
  assign bus.Zmul1xDO     = rnd[0 +: ZM_W];
  assign bus.Zmul2xDO     = rnd[OFF_ZM2 +: ZM_W];
  assign bus.Zmul3xDO     = rnd[OFF_ZM3 +: ZM_W];
  assign bus.Zinv1xDO     = rnd[OFF_ZI1 +: ZI_W];
  assign bus.Zinv2xDO     = rnd[OFF_ZI2 +: ZI_W];
  assign bus.Zinv3xDO     = rnd[OFF_ZI3 +: ZI_W];
  assign bus.BxDO         = rnd[OFF_B +: BLIND_BITS];
endmodule
`default_nettype wire

// File: tb/tb_sbox_rnd_gen.sv
`default_nettype none
// Bench for sbox_rnd_gen: a 1-lane build (SHARES=2) and a 3-lane build (SHARES=3,
// BLIND_BITS=24) checked against an independent LFSR model through scoreboard queues.
module tb_sbox_rnd_gen;
  localparam int RW_A = 26;
  localparam int RW_B = 78;
  localparam logic [31:0] MASK = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sbox_rnd_gen_if #(.SHARES(2), .BLIND_BITS(8))  ia ();
  sbox_rnd_gen_if #(.SHARES(3), .BLIND_BITS(24)) ib ();

  sbox_rnd_gen #(.SHARES(2), .BLIND_BITS(8), .WARMUP(16)) dut_a (
    .ClkxCI(clk), .RstxRI(rst), .bus(ia)
  );
  sbox_rnd_gen #(.SHARES(3), .BLIND_BITS(24), .WARMUP(16)) dut_b (
    .ClkxCI(clk), .RstxRI(rst), .bus(ib)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ma;
  logic [31:0] mb [3];
  logic [RW_A-1:0] qa [$];
  logic [RW_B-1:0] qb [$];
  logic [RW_A-1:0] word_a;
  logic [RW_B-1:0] word_b;

  assign word_a = {ia.BxDO, ia.Zinv3xDO, ia.Zinv2xDO, ia.Zinv1xDO,
                   ia.Zmul3xDO, ia.Zmul2xDO, ia.Zmul1xDO};
  assign word_b = {ib.BxDO, ib.Zinv3xDO, ib.Zinv2xDO, ib.Zinv1xDO,
                   ib.Zmul3xDO, ib.Zmul2xDO, ib.Zmul1xDO};

  function automatic logic [31:0] step32(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < 32; i++) begin
      if (v[0]) v = (v >> 1) ^ MASK;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic logic [RW_B-1:0] model_b();
    logic [95:0] t;
    t = {mb[2], mb[1], mb[0]};
    return t[RW_B-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_a(input logic [31:0] w);
    int n = 0;
    ia.SeedxDI = w;
    ia.SeedValidxSI = 1'b1;
    while (ia.SeedReadyxSO !== 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (n >= 8) begin errors++; $display("FAIL seed_a_timeout ready=%b expected 1", ia.SeedReadyxSO); end
    tick();
    ia.SeedValidxSI = 1'b0;
  endtask

  task automatic seed_b(input logic [31:0] w);
    int n = 0;
    ib.SeedxDI = w;
    ib.SeedValidxSI = 1'b1;
    while (ib.SeedReadyxSO !== 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (n >= 8) begin errors++; $display("FAIL seed_b_timeout ready=%b expected 1", ib.SeedReadyxSO); end
    tick();
    ib.SeedValidxSI = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (ia.SeedReadyxSO !== 1'b0) begin errors++; $display("FAIL reset_ready_a got %b expected 0", ia.SeedReadyxSO); end
    checks++; if (ia.RndValidxSO !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b expected 0", ia.RndValidxSO); end
    checks++; if (ia.ErrxSO !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b expected 0", ia.ErrxSO); end
    checks++; if (word_a !== '0) begin errors++; $display("FAIL reset_data_a got %h expected 0", word_a); end
    checks++; if (ib.SeedReadyxSO !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b expected 0", ib.SeedReadyxSO); end
    checks++; if (word_b !== '0) begin errors++; $display("FAIL reset_data_b got %h expected 0", word_b); end
    rst = 1'b0;
    tick();
    checks++; if (ia.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL load_after_reset_a got %b expected 1", ia.SeedReadyxSO); end
    checks++; if (ib.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL load_after_reset_b got %b expected 1", ib.SeedReadyxSO); end
  endtask

  // Waits out the warmup on lane bank A, then compares the first visible word.
  task automatic warm_a(input string name);
    int n = 0;
    while (ia.RndValidxSO !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL %s_warmup_cycles got %0d expected 16", name, n); end
    for (int i = 0; i < 16; i++) ma = step32(ma);
    qa.push_back(ma[RW_A-1:0]);
    checks++;
    if (word_a !== qa[0]) begin errors++; $display("FAIL %s_first_word got %h expected %h", name, word_a, qa[0]); end
    void'(qa.pop_front());
  endtask

  task automatic test_seed_warmup();
    seed_a(32'h1);
    ma = 32'h1;
    checks++; if (ia.SeedReadyxSO !== 1'b0) begin errors++; $display("FAIL t1_ready_after_word got %b expected 0", ia.SeedReadyxSO); end
    // A second word offered during warmup must be ignored.
    ia.SeedxDI = 32'h2;
    ia.SeedValidxSI = 1'b1;
    warm_a("t1");
    ia.SeedValidxSI = 1'b0;
  endtask

  task automatic test_hold_and_step();
    logic [RW_A-1:0] hold;
    int en;
    hold = word_a;
    ia.EnxSI = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (word_a !== hold) begin errors++; $display("FAIL t3_hold got %h expected %h", word_a, hold); end
    end
    ma = step32(ma);
    qa.push_back(ma[RW_A-1:0]);
    ia.EnxSI = 1'b1;
    tick();
    ia.EnxSI = 1'b0;
    checks++; if (word_a !== qa[0]) begin errors++; $display("FAIL t3_step got %h expected %h", word_a, qa[0]); end
    void'(qa.pop_front());
    for (int i = 0; i < 24; i++) begin
      en = $urandom_range(0, 1);
      ia.EnxSI = (en != 0);
      if (en != 0) ma = step32(ma);
      qa.push_back(ma[RW_A-1:0]);
      tick();
      checks++; if (word_a !== qa[0]) begin errors++; $display("FAIL t3_random_en got %h expected %h", word_a, qa[0]); end
      void'(qa.pop_front());
    end
    ia.EnxSI = 1'b0;
  endtask

  task automatic test_reseed_with_en();
    logic [RW_A-1:0] hold;
    hold = word_a;
    ia.ReseedxSI = 1'b1;
    ia.EnxSI = 1'b1;
    tick();
    ia.ReseedxSI = 1'b0;
    ia.EnxSI = 1'b0;
    checks++; if (ia.RndValidxSO !== 1'b0) begin errors++; $display("FAIL t4_valid got %b expected 0", ia.RndValidxSO); end
    checks++; if (ia.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL t4_ready got %b expected 1", ia.SeedReadyxSO); end
    checks++; if (word_a !== hold) begin errors++; $display("FAIL t4_no_leap got %h expected %h", word_a, hold); end
  endtask

  task automatic test_zero_seed();
    seed_a(32'h0);
    ma = 32'h1;
    warm_a("t2");
  endtask

  task automatic test_multi_lane();
    int en;
    seed_b(32'hDEAD_BEEF);
    checks++; if (ib.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL t5_ready_after_1 got %b expected 1", ib.SeedReadyxSO); end
    // Word offered together with a reseed is dropped and the count restarts.
    ib.SeedxDI = 32'h7777_7777;
    ib.SeedValidxSI = 1'b1;
    ib.ReseedxSI = 1'b1;
    tick();
    ib.ReseedxSI = 1'b0;
    ib.SeedValidxSI = 1'b0;
    checks++; if (ib.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL t5_ready_after_reseed got %b expected 1", ib.SeedReadyxSO); end
    seed_b(32'h1234_5678);
    seed_b(32'h0);
    checks++; if (ib.SeedReadyxSO !== 1'b1) begin errors++; $display("FAIL t5_ready_after_2 got %b expected 1", ib.SeedReadyxSO); end
    seed_b(32'hCAFE_F00D);
    checks++; if (ib.SeedReadyxSO !== 1'b0) begin errors++; $display("FAIL t5_ready_after_3 got %b expected 0", ib.SeedReadyxSO); end
    mb[0] = 32'h1234_5678;
    mb[1] = 32'h1;
    mb[2] = 32'hCAFE_F00D;
    for (int n = 0; n <= 40; n++) begin
      if (ib.RndValidxSO === 1'b1 || n == 40) begin
        checks++;
        if (n != 16) begin errors++; $display("FAIL t5_warmup_cycles got %0d expected 16", n); end
        break;
      end
      tick();
    end
    for (int i = 0; i < 16; i++) for (int l = 0; l < 3; l++) mb[l] = step32(mb[l]);
    qb.push_back(model_b());
    checks++; if (word_b !== qb[0]) begin errors++; $display("FAIL t5_first_word got %h expected %h", word_b, qb[0]); end
    void'(qb.pop_front());
    for (int i = 0; i < 1000; i++) begin
      en = $urandom_range(0, 3);
      ib.EnxSI = (en != 0);
      if (en != 0) for (int l = 0; l < 3; l++) mb[l] = step32(mb[l]);
      qb.push_back(model_b());
      tick();
      checks++; if (word_b !== qb[0]) begin errors++; $display("FAIL t5_word cycle %0d got %h expected %h", i, word_b, qb[0]); end
      void'(qb.pop_front());
    end
    ib.EnxSI = 1'b0;
    checks++; if (ib.RndValidxSO !== 1'b1) begin errors++; $display("FAIL t5_valid_end got %b expected 1", ib.RndValidxSO); end
  endtask

`ifdef RND_HEALTH_EN
  task automatic test_health();
    force dut_a.lane_q = '0;
    tick();
    release dut_a.lane_q;
    checks++; if (ia.ErrxSO !== 1'b1) begin errors++; $display("FAIL t6_err got %b expected 1", ia.ErrxSO); end
    checks++; if (ia.RndValidxSO !== 1'b0) begin errors++; $display("FAIL t6_valid got %b expected 0", ia.RndValidxSO); end
    tick();
    checks++; if (ia.ErrxSO !== 1'b1) begin errors++; $display("FAIL t6_err_sticky got %b expected 1", ia.ErrxSO); end
    seed_a(32'h5);
    ma = 32'h5;
    checks++; if (ia.ErrxSO !== 1'b0) begin errors++; $display("FAIL t6_err_cleared got %b expected 0", ia.ErrxSO); end
    warm_a("t6");
  endtask
`endif

  task automatic test_no_error();
    checks++; if (ia.ErrxSO !== 1'b0) begin errors++; $display("FAIL err_a got %b expected 0", ia.ErrxSO); end
    checks++; if (ib.ErrxSO !== 1'b0) begin errors++; $display("FAIL err_b got %b expected 0", ib.ErrxSO); end
  endtask

  initial begin
    ia.SeedxDI = '0; ia.SeedValidxSI = 1'b0; ia.ReseedxSI = 1'b0; ia.EnxSI = 1'b0;
    ib.SeedxDI = '0; ib.SeedValidxSI = 1'b0; ib.ReseedxSI = 1'b0; ib.EnxSI = 1'b0;
    test_reset();
    test_seed_warmup();
    test_hold_and_step();
    test_reseed_with_en();
    test_zero_seed();
    test_multi_lane();
`ifdef RND_HEALTH_EN
    test_health();
`endif
    test_no_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
